// File: rtl/clint_pkg.sv
// Shared CLINT register map and address decode, used by the bus logic and the bench.
package clint_pkg;

    localparam logic [15:0] MSIP        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP_LO,
        REG_MTIMECMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI
    } reg_sel_e;

    // Decode on the word index only; the byte-lane bits never reach here.
    function automatic reg_sel_e decode_reg(input logic [13:0] word);
        reg_sel_e sel;
        sel = REG_NONE;
        case (word)
            MSIP[15:2]:        sel = REG_MSIP;
            MTIMECMP_LO[15:2]: sel = REG_MTIMECMP_LO;
            MTIMECMP_HI[15:2]: sel = REG_MTIMECMP_HI;
            MTIME_LO[15:2]:    sel = REG_MTIME_LO;
            MTIME_HI[15:2]:    sel = REG_MTIME_HI;
            default:           sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mtime_counter.sv
// Prescaler plus 64-bit mtime counter; a bus write to either half beats the tick.
module mtime_counter #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        sel_hi,
    input  logic [31:0] wdata,
    output logic [63:0] mtime
);

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    logic [15:0] prescaler;
    logic        tick;

    assign tick = (prescaler == PRESC_MAX);

    // Prescaler free-runs regardless of mtime writes so the tick phase is stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime <= '0;
        end else if (we) begin
            if (sel_hi) begin
                mtime[63:32] <= wdata;
            end else begin
                mtime[31:0] <= wdata;
            end
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and mtime behind a single-cycle register bus.
module clint
    import clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    reg_sel_e    sel;
    logic        wr;
    logic        mt_we;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic [31:0] rd_mux;
    logic        vld_p0;
    logic [31:0] rdata_p0;
    logic        timer_irq_p0;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    assign sel   = decode_reg(addr[15:2]);
    assign wr    = req & we;
    assign mt_we = wr & ((sel == REG_MTIME_LO) | (sel == REG_MTIME_HI));

    mtime_counter #(
        .TICK_DIV (TICK_DIV)
    ) u_mtime (
        .clk    (clk),
        .reset  (reset),
        .we     (mt_we),
        .sel_hi (sel == REG_MTIME_HI),
        .wdata  (wdata),
        .mtime  (mtime)
    );

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_MSIP:        rd_mux = {31'd0, msip};
            REG_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
            REG_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
            REG_MTIME_LO:    rd_mux = mtime[31:0];
            REG_MTIME_HI:    rd_mux = mtime[63:32];
            default:         rd_mux = '0;
        endcase
    end

    // p0: access response, register writes and the registered timer compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0       <= 1'b0;
            rdata_p0     <= '0;
            msip         <= 1'b0;
            mtimecmp     <= MTIMECMP_RST;
            timer_irq_p0 <= 1'b0;
        end else begin
            vld_p0       <= req;
            rdata_p0     <= req ? rd_mux : '0;
            timer_irq_p0 <= (mtime >= mtimecmp);
            if (wr) begin
                case (sel)
                    REG_MSIP:        msip           <= wdata[0];
                    REG_MTIMECMP_LO: mtimecmp[31:0]  <= wdata;
                    REG_MTIMECMP_HI: mtimecmp[63:32] <= wdata;
                    default:         ;
                endcase
            end
        end
    end

    // An ack already registered is suppressed as soon as reset rises.
    assign ack                = vld_p0 & ~reset;
    assign rdata              = ack ? rdata_p0 : '0;
    assign timer_interrupt    = timer_irq_p0;
    assign software_interrupt = msip;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: one instance with TICK_DIV=1 and one with TICK_DIV=4 share the bus.
module tb_clint;
    import clint_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [15:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata1, rdata4;
    logic        ack1, ack4, ti1, ti4, si1, si4;

    int n_checks = 0;
    int n_errors = 0;
    int ecount   = 0;
    logic [31:0] r1, r4;

    always #5 clk = ~clk;

    // Clock edges since reset release; equals mtime of the TICK_DIV=1 unit until it is written.
    always @(posedge clk) begin
        if (reset) ecount <= 0;
        else       ecount <= ecount + 1;
    end

    clint #(.TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ack(ack1), .timer_interrupt(ti1), .software_interrupt(si1)
    );

    clint #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata4), .ack(ack4), .timer_interrupt(ti4), .software_interrupt(si4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic access(input logic w, input logic [15:0] a, input logic [31:0] d,
                          output logic [31:0] o1, output logic [31:0] o4);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        step(1);
        req = 1'b0;
        we  = 1'b0;
        check("ack", {ack4, ack1}, 2'b11);
        o1 = rdata1;
        o4 = rdata4;
    endtask

    task automatic wait_ecount(input int n);
        int budget = 0;
        while (ecount < n && budget < 500) begin
            step(1);
            budget++;
        end
        check("wait_ecount", ecount, n);
    endtask

    initial begin
        // Reset state, sampled while reset is still high
        step(2);
        check("rst_ack", {ack4, ack1}, 2'b00);
        check("rst_rdata", rdata1, 32'd0);
        check("rst_irq", {ti4, ti1, si4, si1}, 4'b0000);

        // Idle count with TICK_DIV=1
        apply_reset();
        wait_ecount(10);
        access(1'b0, MTIME_LO, 32'd0, r1, r4);
        check("idle_mtime_lo", r1, 32'd10);
        check("idle_ti", ti1, 1'b0);
        check("idle_si", si1, 1'b0);
        step(1);
        check("idle_ack_low", ack1, 1'b0);
        check("idle_rdata_zero", rdata1, 32'd0);

        // Timer compare rise and clear
        apply_reset();
        access(1'b1, MTIMECMP_HI, 32'd0, r1, r4);
        access(1'b1, MTIMECMP_LO, 32'd20, r1, r4);
        check("cmp_ti_before", ti1, 1'b0);
        wait_ecount(20);
        check("cmp_ti_at20", ti1, 1'b0);
        step(1);
        check("cmp_ti_at21", ti1, 1'b1);
        step(3);
        check("cmp_ti_held", ti1, 1'b1);
        access(1'b1, MTIMECMP_LO, 32'hFFFF_FFFF, r1, r4);
        check("cmp_ti_write_cycle", ti1, 1'b1);
        step(1);
        check("cmp_ti_cleared", ti1, 1'b0);

        // mtime carry into the upper half and 64-bit wrap
        apply_reset();
        access(1'b1, MTIME_LO, 32'hFFFF_FFFF, r1, r4);
        access(1'b1, MTIME_HI, 32'd0, r1, r4);
        access(1'b0, MTIME_LO, 32'd0, r1, r4);
        check("carry_lo_held", r1, 32'hFFFF_FFFF);
        access(1'b0, MTIME_HI, 32'd0, r1, r4);
        check("carry_hi", r1, 32'd1);
        access(1'b0, MTIME_LO, 32'd0, r1, r4);
        check("carry_lo_after", r1, 32'd1);
        access(1'b1, MTIME_HI, 32'hFFFF_FFFF, r1, r4);
        access(1'b1, MTIME_LO, 32'hFFFF_FFFF, r1, r4);
        access(1'b0, MTIME_LO, 32'd0, r1, r4);
        check("wrap_lo_ones", r1, 32'hFFFF_FFFF);
        check("wrap_ti_equal", ti1, 1'b1);
        access(1'b0, MTIME_HI, 32'd0, r1, r4);
        check("wrap_hi_zero", r1, 32'd0);
        check("wrap_ti_cleared", ti1, 1'b0);
        access(1'b0, MTIME_LO, 32'd0, r1, r4);
        check("wrap_lo_one", r1, 32'd1);

        // TICK_DIV=4: divided rate and write-over-tick priority
        apply_reset();
        wait_ecount(3);
        access(1'b0, MTIME_LO, 32'd0, r1, r4);
        check("div4_before_tick", r4, 32'd0);
        access(1'b0, MTIME_LO, 32'd0, r1, r4);
        check("div4_first_tick", r4, 32'd1);
        wait_ecount(7);
        access(1'b1, MTIME_LO, 32'd100, r1, r4);
        access(1'b0, MTIME_LO, 32'd0, r1, r4);
        check("div4_write_wins", r4, 32'd100);
        wait_ecount(11);
        access(1'b0, MTIME_LO, 32'd0, r1, r4);
        check("div4_hold", r4, 32'd100);
        access(1'b0, MTIME_LO, 32'd0, r1, r4);
        check("div4_next_tick", r4, 32'd101);

        // msip, unmapped offsets and ignored byte-lane bits
        apply_reset();
        check("msip_si_init", si1, 1'b0);
        access(1'b1, MSIP, 32'hFFFF_FFFF, r1, r4);
        check("msip_si_set", {si4, si1}, 2'b11);
        access(1'b0, MSIP, 32'd0, r1, r4);
        check("msip_read", r1, 32'd1);
        access(1'b1, MSIP, 32'd0, r1, r4);
        check("msip_si_clr", si1, 1'b0);
        access(1'b1, 16'h1234, 32'hDEAD_BEEF, r1, r4);
        access(1'b0, 16'h1234, 32'd0, r1, r4);
        check("unmapped_read", r1, 32'd0);
        access(1'b0, 16'h4001, 32'd0, r1, r4);
        check("alias_cmp_lo", r1, 32'hFFFF_FFFF);

        // Back-to-back requests with reset during the second ack
        apply_reset();
        req = 1'b1; we = 1'b1; addr = MSIP; wdata = 32'd1;
        step(1);
        check("b2b_ack1", {ack4, ack1}, 2'b11);
        addr = MTIMECMP_LO; wdata = 32'd5;
        step(1);
        addr = MTIMECMP_HI; wdata = 32'd0;
        reset = 1'b1;
        #1;
        check("b2b_ack2_dropped", {ack4, ack1}, 2'b00);
        step(1);
        req = 1'b0; we = 1'b0;
        check("b2b_ack3_dropped", {ack4, ack1}, 2'b00);
        check("b2b_si_reset", si1, 1'b0);
        step(1);
        reset = 1'b0;
        check("b2b_ack_after", {ack4, ack1}, 2'b00);
        step(1);
        check("b2b_ack_idle", {ack4, ack1}, 2'b00);
        access(1'b0, MSIP, 32'd0, r1, r4);
        check("b2b_msip", r1, 32'd0);
        access(1'b0, MTIMECMP_LO, 32'd0, r1, r4);
        check("b2b_cmp_lo", r1, 32'hFFFF_FFFF);
        access(1'b0, MTIMECMP_HI, 32'd0, r1, r4);
        check("b2b_cmp_hi", r1, 32'hFFFF_FFFF);
        check("b2b_irq", {ti1, si1}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1, meaning clk cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  1  bus access request, valid for one cycle per access.
REQ-005 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-006 SHALL have port addr  input  16  byte offset of the register; bits [1:0] ignored.
REQ-007 SHALL have port wdata  input  32  write data; full-word writes only.
REQ-008 SHALL have port rdata  output  32  read data, valid while ack is high.
REQ-009 SHALL have port ack  output  1  access-complete pulse.
REQ-010 SHALL have port timer_interrupt  output  1  machine timer pending, routed to the CSR block.
REQ-011 SHALL have port software_interrupt  output  1  machine software pending, routed to the CSR block.

Function
REQ-012 SHALL decode the following registers: 0x0000 msip (bit 0 only; bits 31:1 read 0); 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
REQ-013 SHALL return 0 on reads of any other offset, ignore writes to it, and still acknowledge the access.
REQ-014 SHALL assert ack for exactly one cycle in the cycle after each req, with no wait states.
REQ-015 SHALL accept req on consecutive cycles, giving one ack per req in order, even when req coincides with ack.
REQ-016 SHALL drive rdata, in the ack cycle, with the register value as it stood in the req cycle, before any same-cycle update; rdata SHALL be 0 when ack is low.
REQ-017 SHALL keep a prescaler counting 0..TICK_DIV-1 that wraps to 0; each wrap is a tick; with TICK_DIV=1 every cycle is a tick.
REQ-018 SHALL increment the 64-bit mtime by 1 on each tick, wrapping from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-019 SHALL give a write to an mtime half priority over the tick in the same cycle: the written half takes wdata, the other half holds, and that tick's increment is dropped.
REQ-020 SHALL leave the prescaler unaffected by mtime writes.
REQ-021 SHALL load the selected mtimecmp half with wdata on a write, leaving the other half unchanged.
REQ-022 SHALL register timer_interrupt as (mtime >= mtimecmp), unsigned 64-bit, so the output reflects the comparison one cycle after the state change.
REQ-023 SHALL drive software_interrupt directly from the msip bit 0 register, with no further delay.
REQ-024 SHALL have no internal interrupt clear: timer_interrupt clears only when mtimecmp is written above mtime or mtime is written below mtimecmp.

Reset
REQ-025 SHALL, while reset is high, set mtime=0, prescaler=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, ack=0, rdata=0, timer_interrupt=0, software_interrupt=0.
REQ-026 SHALL drop a req in flight when reset is asserted: no ack is produced for it.
REQ-027 SHALL ignore req on any cycle in which reset is high.

Structure
REQ-028 SHALL place the register offset constants (MSIP, MTIMECMP_LO/HI, MTIME_LO/HI) in a shared package, clint_pkg, for reuse by the bus decoder and the bench.
REQ-029 SHALL implement the prescaler plus the 64-bit mtime counter as one sub-module, mtime_counter, with tick, write-enable and half-select inputs.
REQ-030 SHALL keep the register decode, read mux, compare logic and ack logic in clint itself.

Verification
REQ-031 Reset then idle 10 cycles, TICK_DIV=1 -> mtime reads 10 +/- access latency; timer_interrupt=0; software_interrupt=0.
REQ-032 Write mtimecmp_hi=0, then mtimecmp_lo=20, TICK_DIV=1 -> timer_interrupt rises exactly one cycle after mtime reaches 20; a later write of mtimecmp_lo=0xFFFF_FFFF clears it the cycle after that write.
REQ-033 Write mtime_lo=0xFFFF_FFFF, mtime_hi=0 -> the next tick gives mtime=0x1_0000_0000; mtime=all-ones wraps to 0 on the tick after.
REQ-034 TICK_DIV=4 -> mtime advances once per 4 cycles; a write to mtime_lo=100 coincident with a tick leaves mtime=100, and it reaches 101 four cycles later.
REQ-035 Write msip=0xFFFF_FFFF -> software_interrupt=1 the next cycle and msip reads 1; write 0 -> the output drops next cycle; a read of 0x1234 gives 0 with ack.
REQ-036 Back-to-back req on 3 cycles, with reset asserted during the second ack -> the first ack is seen, no further acks, and all registers are at reset values.
